puf_launch_sampler: RTL and testbench
=====================================

Name: puf_launch_sampler

Overview:
Control stage wrapped around the chain of PDL-based switch stages. Upstream, it drives the per-stage top/bottom select vectors and the launch edge into i1/i2 of the first stage. Downstream, it samples the arbiter output behind the last stage. It repeats each challenge NUM_TRIALS times, counts arbiter "1" outcomes, and returns a majority-voted response bit with a valid pulse.

Parameters:
NUM_STAGES, 64, number of switch stages in the chain; width of the select vectors
NUM_TRIALS, 15, launches per challenge; must be odd and >= 1
SETTLE_CYCLES, 8, clock cycles S allowed for the chain to settle per phase; must be >= 1
CNT_W, clog2(NUM_TRIALS+1), width of the trial counter and the ones counter

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
start  in  1  request a measurement; accepted only in IDLE
challenge  in  NUM_STAGES  challenge bits, captured when start is accepted
tune_mask  in  NUM_STAGES  PDL tuning mask for the bottom selects, captured with challenge
arbiter_in  in  1  raw arbiter output from behind the last stage; asynchronous to clk
sel_top  out  NUM_STAGES  select_tp of each stage = captured challenge
sel_btm  out  NUM_STAGES  select_btm of each stage = captured challenge XOR captured tune_mask
launch  out  1  launch signal into i1/i2 of stage 0
busy  out  1  high in every state except IDLE
valid  out  1  one-cycle pulse when the response is ready
response  out  1  majority-voted response bit
ones_count  out  CNT_W  number of trials that sampled 1

Behaviour:
- Reset (async): all outputs and registers go to 0 and the FSM enters IDLE. launch drops immediately, including mid-FIRE. The synchronizer flops clear. No response is produced for an aborted measurement.
- arbiter_in passes through a 2-flop synchronizer, reset value 0. Only the synchronized value is ever used.
- FSM states: IDLE, SETUP, FIRE, DONE.
- IDLE, start=1:
  - Register challenge and tune_mask.
  - Clear ones_count and the trial counter.
  - Move to SETUP.
  - start is ignored in every other state, and whenever busy=1.
- SETUP: launch=0 for exactly S cycles. This lets the chain relax and settle the selects. Then move to FIRE.
- FIRE: launch=1 for exactly S+2 cycles; the +2 covers synchronizer latency.
  - On the last FIRE cycle, add the synchronized arbiter bit to ones_count.
  - If the trial counter equals NUM_TRIALS-1, move to DONE. Otherwise increment the trial counter and return to SETUP.
- DONE (1 cycle):
  - valid=1.
  - response = (ones_count > NUM_TRIALS/2), registered so that it appears in the same cycle as valid.
  - Return to IDLE.
- Latency: if start is sampled in cycle T, valid is high in cycle T + 1 + NUM_TRIALS*(2S+2). With the defaults this is T + 271.
- Holding:
  - sel_top and sel_btm hold the captured value from acceptance until the next accepted start; they are never changed while busy.
  - response and ones_count hold after DONE until the next accepted start, which clears ones_count.
  - response clears only on reset.
- Arithmetic: ones_count saturates naturally; the maximum value NUM_TRIALS fits in CNT_W. The trial counter never wraps past NUM_TRIALS-1.
- Simultaneous events: start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.
- Parameter check at elaboration: fail if NUM_TRIALS is even or 0, or if SETTLE_CYCLES < 1.

Decomposition:
- Package puf_ctrl_pkg:
  - FSM state enum (IDLE, SETUP, FIRE, DONE)
  - clog2 helper function
  - default constants for NUM_STAGES, NUM_TRIALS, SETTLE_CYCLES
- Sub-module arbiter_sync: 2-flop synchronizer with async active-high reset. Instantiated with KEEP_HIERARCHY so that placement constraints can target it.
- Phase timer and trial counter stay in the top module.

Test Plan:
- NUM_TRIALS=15, S=8, arbiter_in tied 1, start at cycle T -> valid exactly at T+271, response=1, ones_count=15, launch pulses 15 times of 10 cycles each.
- arbiter_in tied 0 -> response=0, ones_count=0. Repeat with 8 trials driven to 1 -> response=1, count=8. Repeat with 7 trials driven to 1 -> response=0, count=7.
- challenge=64'hA5A5_0000_FFFF_1234, tune_mask=64'h0000_0000_0000_00FF -> sel_top=challenge, sel_btm=64'hA5A5_0000_FFFF_12CB. Change challenge while busy -> sel outputs unchanged.
- Pulse start repeatedly while busy -> no restart, a single valid pulse, latency unchanged.
- Assert reset in the 3rd cycle of FIRE -> launch, busy, valid, ones_count all 0 in the same cycle. After release, a new start completes normally.
- NUM_TRIALS=1, S=1 -> valid at T+5, response equals the synchronized arbiter value on the last FIRE cycle.

Source files
------------

// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the PUF launch/sample control logic.
//   state_t           : measurement FSM states
//   clog2()           : ceiling log2, never below 1 so it can size a vector
//   DEF_NUM_STAGES    : default switch-stage count
//   DEF_NUM_TRIALS    : default launches per challenge (odd)
//   DEF_SETTLE_CYCLES : default settle cycles per phase
package puf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_STAGES    = 64;
  localparam int unsigned DEF_NUM_TRIALS    = 15;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/puf_launch_sampler_arbiter_sync.sv
// Two-flop synchronizer for the raw arbiter output.
//   clk      : sampling clock
//   reset    : asynchronous active-high reset, clears both flops
//   i_async  : arbiter output, asynchronous to clk
//   o_sync   : synchronized arbiter value (2-cycle latency)
module arbiter_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/puf_launch_sampler.sv
// Launch/sample controller around the PDL switch-stage chain. Drives the
// per-stage selects and the launch edge, samples the arbiter behind the
// last stage, repeats NUM_TRIALS launches and returns a majority vote.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : measurement request, accepted only in IDLE
//   challenge   : challenge bits, captured on accept
//   tune_mask   : PDL tuning mask for bottom selects, captured on accept
//   arbiter_in  : raw arbiter output (asynchronous)
//   sel_top     : captured challenge
//   sel_btm     : captured challenge XOR captured tune_mask
//   launch      : launch edge into stage 0
//   busy        : high outside IDLE
//   valid       : one-cycle pulse with the response
//   response    : majority-voted response bit
//   ones_count  : number of trials that sampled 1
module puf_launch_sampler
  import puf_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_STAGES    = DEF_NUM_STAGES,
  parameter  int unsigned NUM_TRIALS    = DEF_NUM_TRIALS,
  parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int unsigned CNT_W         = clog2(NUM_TRIALS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] challenge,
  input  logic [NUM_STAGES-1:0] tune_mask,
  input  logic                  arbiter_in,
  output logic [NUM_STAGES-1:0] sel_top,
  output logic [NUM_STAGES-1:0] sel_btm,
  output logic                  launch,
  output logic                  busy,
  output logic                  valid,
  output logic                  response,
  output logic [CNT_W-1:0]      ones_count
);

  if (((NUM_TRIALS % 2) == 0) || (SETTLE_CYCLES < 1)) begin : g_bad_params
    $error("puf_launch_sampler: NUM_TRIALS must be odd and SETTLE_CYCLES >= 1");
  end

  localparam int unsigned TMR_W = clog2(SETTLE_CYCLES + 2);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETTLE_CYCLES - 1);
  // FIRE is two cycles longer so the synchronizer sees the settled arbiter.
  localparam logic [TMR_W-1:0] FIRE_LAST  = TMR_W'(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIAL_LAST = CNT_W'(NUM_TRIALS - 1);
  localparam logic [CNT_W-1:0] HALF       = CNT_W'(NUM_TRIALS / 2);

  state_t                r_state;
  logic [TMR_W-1:0]      r_timer;
  logic [CNT_W-1:0]      r_trial;
  logic [CNT_W-1:0]      r_ones;
  logic [NUM_STAGES-1:0] r_chal;
  logic [NUM_STAGES-1:0] r_tune;
  logic                  r_launch;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_resp;

  logic                  w_sync;
  logic [CNT_W-1:0]      w_ones_next;

  (* keep_hierarchy = "yes" *)
  arbiter_sync u_arbiter_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (arbiter_in),
    .o_sync  (w_sync)
  );

  assign w_ones_next = r_ones + CNT_W'(w_sync);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_trial  <= '0;
      r_ones   <= '0;
      r_chal   <= '0;
      r_tune   <= '0;
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_chal  <= challenge;
            r_tune  <= tune_mask;
            r_ones  <= '0;
            r_trial <= '0;
            r_timer <= '0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_timer == SETUP_LAST) begin
            r_timer  <= '0;
            r_launch <= 1'b1;
            r_state  <= FIRE;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        FIRE: begin
          if (r_timer == FIRE_LAST) begin
            r_timer  <= '0;
            r_launch <= 1'b0;
            r_ones   <= w_ones_next;
            if (r_trial == TRIAL_LAST) begin
              // Vote on the updated count so response lands with valid.
              r_valid <= 1'b1;
              r_resp  <= (w_ones_next > HALF);
              r_state <= DONE;
            end else begin
              r_trial <= r_trial + CNT_ONE;
              r_state <= SETUP;
            end
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel_top    = r_chal;
  assign sel_btm    = r_chal ^ r_tune;
  assign launch     = r_launch;
  assign busy       = r_busy;
  assign valid      = r_valid;
  assign response   = r_resp;
  assign ones_count = r_ones;

endmodule

// File: tb/tb_puf_launch_sampler.sv
module tb_puf_launch_sampler;

  localparam int NS  = 64;
  localparam int NT  = 15;
  localparam int S   = 8;
  localparam int LAT = 1 + NT * (2 * S + 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NS-1:0] challenge;
  logic [NS-1:0] tune_mask;
  logic          arbiter_in;
  logic [NS-1:0] sel_top;
  logic [NS-1:0] sel_btm;
  logic          launch;
  logic          busy;
  logic          valid;
  logic          response;
  logic [3:0]    ones_count;

  logic          b_start;
  logic [7:0]    b_challenge;
  logic [7:0]    b_tune_mask;
  logic          b_arb;
  logic [7:0]    b_sel_top;
  logic [7:0]    b_sel_btm;
  logic          b_launch;
  logic          b_busy;
  logic          b_valid;
  logic          b_response;
  logic [0:0]    b_ones_count;

  always #5 clk = ~clk;

  puf_launch_sampler #(
    .NUM_STAGES   (NS),
    .NUM_TRIALS   (NT),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .challenge (challenge),
    .tune_mask (tune_mask),
    .arbiter_in(arbiter_in),
    .sel_top   (sel_top),
    .sel_btm   (sel_btm),
    .launch    (launch),
    .busy      (busy),
    .valid     (valid),
    .response  (response),
    .ones_count(ones_count)
  );

  puf_launch_sampler #(
    .NUM_STAGES   (8),
    .NUM_TRIALS   (1),
    .SETTLE_CYCLES(1)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (b_start),
    .challenge (b_challenge),
    .tune_mask (b_tune_mask),
    .arbiter_in(b_arb),
    .sel_top   (b_sel_top),
    .sel_btm   (b_sel_btm),
    .launch    (b_launch),
    .busy      (b_busy),
    .valid     (b_valid),
    .response  (b_response),
    .ones_count(b_ones_count)
  );

  typedef struct {
    logic       resp;
    logic [3:0] cnt;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         o_lat, o_valids, o_pulses, o_pmin, o_pmax, o_selbad;
  logic       o_resp;
  logic [3:0] o_cnt;
  logic       o_busy_after, o_busy_chain;

  function automatic logic [3:0] popcount15(input logic [14:0] p);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 15; i++) c = c + {3'b000, p[i]};
    return c;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb.size() == 0) begin
      e.resp = 1'bx; e.cnt = 4'hx; e.lat = -99;
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  // Drives one measurement on the default instance; arbiter_in takes
  // pat[i] at the rise of launch for trial i and holds through that trial.
  task automatic run_a(input logic [14:0] pat, input bit spam, input bit chain,
                       input bit scramble, input logic [NS-1:0] exp_top,
                       input logic [NS-1:0] exp_btm);
    int   idx  = 0;
    int   plen = 0;
    int   vk   = 0;
    logic prev_l = 1'b0;
    bit   seen = 1'b0;
    o_lat = -1; o_valids = 0; o_pulses = 0; o_pmin = 1000; o_pmax = 0;
    o_selbad = 0; o_resp = 1'bx; o_cnt = 4'hx;
    o_busy_after = 1'bx; o_busy_chain = 1'bx;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (!seen) begin
        start = spam;
      end else if (k == vk + 1) begin
        o_busy_after = busy;
        if (!chain) start = 1'b0;
      end else if (chain && k == vk + 2) begin
        o_busy_chain = busy;
        start = 1'b0;
        break;
      end
      if (launch && !prev_l) begin
        o_pulses++;
        if (idx < 15) arbiter_in = pat[idx];
        idx++;
        plen = 1;
      end else if (launch) begin
        plen++;
      end else if (prev_l) begin
        if (plen < o_pmin) o_pmin = plen;
        if (plen > o_pmax) o_pmax = plen;
      end
      prev_l = launch;
      if (busy && (sel_top !== exp_top || sel_btm !== exp_btm)) o_selbad++;
      if (scramble) begin
        challenge = {$urandom, $urandom};
        tune_mask = {$urandom, $urandom};
      end
      if (valid) begin
        o_valids++;
        if (!seen) begin
          seen = 1'b1; vk = k; o_lat = k; o_resp = response; o_cnt = ones_count;
        end
      end
      if (!chain && seen && k >= vk + 5) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; challenge = '0; tune_mask = '0; arbiter_in = 1'b0;
    b_start = 1'b0; b_challenge = '0; b_tune_mask = '0; b_arb = 1'b0;
    #1;
    challenge = '1;
    @(negedge clk);
    checks++;
    if ({launch, busy, valid, response, ones_count} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000000",
                         {launch, busy, valid, response, ones_count});
    end
    checks++;
    if (sel_top !== '0 || sel_btm !== '0) begin
      errors++; $display("FAIL reset_sel got=%h/%h exp=0/0", sel_top, sel_btm);
    end
    checks++;
    if ({b_launch, b_busy, b_valid, b_response, b_ones_count} !== 5'b0) begin
      errors++; $display("FAIL reset_b got=%b exp=00000",
                         {b_launch, b_busy, b_valid, b_response, b_ones_count});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pattern(input string name, input logic [14:0] pat, input bit full);
    exp_t e;
    logic [NS-1:0] ch;
    ch = {$urandom, $urandom};
    challenge = ch; tune_mask = '0;
    sb.push_back('{resp: (popcount15(pat) > 4'd7), cnt: popcount15(pat), lat: LAT});
    run_a(pat, 1'b0, 1'b0, 1'b0, ch, ch);
    e = pop_exp();
    checks++;
    if (o_lat !== e.lat) begin
      errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, o_lat, e.lat);
    end
    checks++;
    if (o_resp !== e.resp) begin
      errors++; $display("FAIL %s_response got=%b exp=%b", name, o_resp, e.resp);
    end
    checks++;
    if (o_cnt !== e.cnt) begin
      errors++; $display("FAIL %s_count got=%0d exp=%0d", name, o_cnt, e.cnt);
    end
    if (full) begin
      checks++;
      if (o_pulses !== NT || o_pmin !== S + 2 || o_pmax !== S + 2) begin
        errors++; $display("FAIL %s_launch got=%0d pulses len %0d..%0d exp=%0d pulses len %0d",
                           name, o_pulses, o_pmin, o_pmax, NT, S + 2);
      end
      checks++;
      if (o_valids !== 1) begin
        errors++; $display("FAIL %s_valid_pulses got=%0d exp=1", name, o_valids);
      end
      checks++;
      if (response !== e.resp || ones_count !== e.cnt || busy !== 1'b0) begin
        errors++; $display("FAIL %s_hold got=%b/%0d/%b exp=%b/%0d/0",
                           name, response, ones_count, busy, e.resp, e.cnt);
      end
    end
  endtask

  task automatic test_selects();
    logic [NS-1:0] ch, tm, exp_btm;
    ch = 64'hA5A5_0000_FFFF_1234;
    tm = 64'h0000_0000_0000_00FF;
    exp_btm = 64'hA5A5_0000_FFFF_12CB;
    challenge = ch; tune_mask = tm;
    run_a(15'h0F0F, 1'b0, 1'b0, 1'b1, ch, exp_btm);
    checks++;
    if (sel_top !== ch) begin
      errors++; $display("FAIL sel_top got=%h exp=%h", sel_top, ch);
    end
    checks++;
    if (sel_btm !== exp_btm) begin
      errors++; $display("FAIL sel_btm got=%h exp=%h", sel_btm, exp_btm);
    end
    checks++;
    if (o_selbad !== 0) begin
      errors++; $display("FAIL sel_stable_while_busy got=%0d bad cycles exp=0", o_selbad);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat2 = -1;
    logic [NS-1:0] ch;
    ch = 64'h0123_4567_89AB_CDEF;
    challenge = ch; tune_mask = '0;
    sb.push_back('{resp: 1'b1, cnt: 4'd15, lat: LAT});
    sb.push_back('{resp: 1'b1, cnt: 4'd15, lat: LAT});
    run_a(15'h7FFF, 1'b1, 1'b1, 1'b0, ch, ch);
    e = pop_exp();
    checks++;
    if (o_lat !== e.lat || o_valids !== 1) begin
      errors++; $display("FAIL spam_start got=lat %0d valids %0d exp=lat %0d valids 1",
                         o_lat, o_valids, e.lat);
    end
    checks++;
    if (o_busy_after !== 1'b0) begin
      errors++; $display("FAIL start_in_done_ignored got=busy %b exp=0", o_busy_after);
    end
    checks++;
    if (o_busy_chain !== 1'b1) begin
      errors++; $display("FAIL start_after_done_accepted got=busy %b exp=1", o_busy_chain);
    end
    for (int k = 2; k <= LAT + 10; k++) begin
      @(negedge clk);
      if (valid) begin lat2 = k; break; end
    end
    e = pop_exp();
    checks++;
    if (lat2 !== e.lat || response !== e.resp || ones_count !== e.cnt) begin
      errors++; $display("FAIL chained_run got=lat %0d resp %b cnt %0d exp=lat %0d resp %b cnt %0d",
                         lat2, response, ones_count, e.lat, e.resp, e.cnt);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_fire();
    int   rises = 0;
    logic prev_l = 1'b0;
    challenge = 64'hDEAD_BEEF_0000_1111; tune_mask = '0; arbiter_in = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (launch && !prev_l) rises++;
      prev_l = launch;
      if (rises == 2) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (launch !== 1'b1 || ones_count !== 4'd1 || rises !== 2) begin
      errors++; $display("FAIL pre_reset_fire got=launch %b cnt %0d rises %0d exp=launch 1 cnt 1 rises 2",
                         launch, ones_count, rises);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({launch, busy, valid, response, ones_count} !== 8'h00) begin
      errors++; $display("FAIL async_reset_mid_fire got=%b exp=00000000",
                         {launch, busy, valid, response, ones_count});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_pattern("after_reset", 15'h7FFF, 1'b0);
  endtask

  task automatic test_single_trial(input logic bitval);
    int lat = -1;
    logic r = 1'bx;
    logic [0:0] c = 1'bx;
    logic prev_l = 1'b0;
    exp_t e;
    sb.push_back('{resp: bitval, cnt: {3'b000, bitval}, lat: 5});
    b_challenge = 8'h3C;
    @(negedge clk);
    b_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_launch && !prev_l) b_arb = bitval;
      prev_l = b_launch;
      if (b_valid) begin lat = k; r = b_response; c = b_ones_count; break; end
    end
    e = pop_exp();
    checks++;
    if (lat !== e.lat) begin
      errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, e.lat);
    end
    checks++;
    if (r !== e.resp || {3'b000, c} !== e.cnt) begin
      errors++; $display("FAIL single_result got=resp %b cnt %0d exp=resp %b cnt %0d",
                         r, c, e.resp, e.cnt);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pattern("all_ones", 15'h7FFF, 1'b1);
    test_pattern("all_zeros", 15'h0000, 1'b1);
    test_pattern("eight_ones", 15'h00FF, 1'b0);
    test_pattern("seven_ones", 15'h007F, 1'b0);
    test_pattern("mixed", 15'h5A96, 1'b0);
    test_selects();
    test_back_to_back();
    test_reset_mid_fire();
    test_single_trial(1'b1);
    test_single_trial(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
